// File: rtl/alu_seq_exec.sv
// EX-stage ALU: add/comp/and/xor complete in one cycle, shifts iterate one bit per cycle.
// Define ALU_SEQ_BARREL_SHIFT_EN to compute shifts with a single-cycle barrel shifter instead.
module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_NONE, SH_SLL, SH_SRL, SH_SRA} shift_t;

    state_t             state, state_nx;
    shift_t             kind;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;
    logic               finish_op;

    assign amt = b[SHAMT_W-1:0];

    // Single-cycle operation decode; bit 3 only matters where it selects a different op.
    always_comb begin
        kind     = SH_NONE;
        sum_ext  = '0;
        op_res   = '0;
        op_carry = 1'b0;
        case (ALU_control)
            4'b0000, 4'b1000, 4'b0111: sum_ext = {1'b0, a} + {1'b0, b};
            4'b0001, 4'b1001:          sum_ext = {1'b0, ~b} + (WIDTH+1)'(1);
            4'b0010:                   sum_ext = {1'b0, a & b};
            4'b0011:                   sum_ext = {1'b0, a ^ b};
            4'b0100, 4'b1100:          kind = SH_SLL;
            4'b0101, 4'b1101:          kind = SH_SRL;
            4'b0110, 4'b1110:          kind = SH_SRA;
            default:                   sum_ext = '0;
        endcase
        {op_carry, op_res} = sum_ext;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
        // Extra guard bit catches the last bit shifted out (stays 0 for amount 0).
        case (kind)
            SH_SLL:  {op_carry, op_res} = {1'b0, a} << amt;
            SH_SRL:  {op_res, op_carry} = {a, 1'b0} >> amt;
            SH_SRA:  {op_res, op_carry} = (WIDTH+1)'($signed({a, 1'b0}) >>> amt);
            default: ;
        endcase
`else
        if (kind != SH_NONE) begin
            op_res   = a;
            op_carry = 1'b0;
        end
`endif
    end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   work, work_nx;
    shift_t             skind;
    logic               work_out;
    logic               load_shift, step, finish_shift;

    // One-bit step of the working register and the bit leaving it.
    always_comb begin
        work_nx  = work;
        work_out = 1'b0;
        case (skind)
            SH_SLL:  begin work_nx = {work[WIDTH-2:0], 1'b0};        work_out = work[WIDTH-1]; end
            SH_SRL:  begin work_nx = {1'b0, work[WIDTH-1:1]};        work_out = work[0];       end
            SH_SRA:  begin work_nx = {work[WIDTH-1], work[WIDTH-1:1]}; work_out = work[0];     end
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_nx  = state;
        finish_op = 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        load_shift   = 1'b0;
        step         = 1'b0;
        finish_shift = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
`ifndef ALU_SEQ_BARREL_SHIFT_EN
                    if (kind != SH_NONE && amt != '0) begin
                        load_shift = 1'b1;
                        state_nx   = SHIFT;
                    end else
`endif
                    begin
                        finish_op = 1'b1;
                        state_nx  = DONE;
                    end
                end
            end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            SHIFT: begin
                step = 1'b1;
                if (count == SHAMT_W'(1)) begin
                    finish_shift = 1'b1;
                    state_nx     = DONE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            sign   <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            count  <= '0;
            work   <= '0;
            skind  <= SH_NONE;
`endif
        end else begin
            state <= state_nx;
            busy  <= (state_nx == SHIFT);
            done  <= (state_nx == DONE);
            if (finish_op) begin
                result <= op_res;
                carry  <= op_carry;
                zero   <= (op_res == '0);
                sign   <= op_res[WIDTH-1];
            end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            if (load_shift) begin
                count <= amt;
                work  <= a;
                skind <= kind;
            end
            if (step) begin
                count <= count - SHAMT_W'(1);
                work  <= work_nx;
                carry <= work_out;
            end
            if (finish_shift) begin
                result <= work_nx;
                zero   <= (work_nx == '0);
                sign   <= work_nx[WIDTH-1];
            end
`endif
        end
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Performs add, two's-complement, AND, XOR and the six shift variants on 32-bit operands.
- Shifts run iteratively, one bit per cycle, under a start/busy/done handshake.
- Sits in the EX stage of the multi-cycle datapath; the main control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; shift amount = b[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- ALU_control  in  4  operation code, sampled with start.
- a  in  WIDTH  operand A (value to be shifted for shifts).
- b  in  WIDTH  operand B (amount source for shifts), sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result/flags valid from this cycle on.
- result  out  WIDTH  registered result, held until next done.
- carry  out  1  add/comp carry-out; last bit shifted out for shifts; 0 otherwise.
- zero  out  1  result==0.
- sign  out  1  result[WIDTH-1].

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, carry=0, zero=0, sign=0; shift counter=0.
- Reset during SHIFT aborts the operation. No done pulse is produced, and outputs clear as above.
- Op codes:
  - 0000, 1000, 0111: result = a + b (WIDTH+1-bit sum); carry = bit WIDTH.
  - 0001, 1001: result = ~b + 1; carry = carry-out of that add (1 only for b=0).
  - 0010: a & b. 0011: a ^ b.
  - 1100, 0100: shift left logical.
  - 1101, 0101: shift right logical.
  - 1110, 0110: shift right arithmetic (sign bit replicated).
  - Bit3 (immediate vs variable) does not change behaviour here; operand selection is upstream.
  - Any other code: result=0, carry=0, completes as a non-shift op.
- FSM states IDLE, SHIFT, DONE.
  - IDLE + start: latch code, a, b.
  - Non-shift op, or shift with amount 0: go to DONE and register result/flags.
  - Shift with amount n>0: load counter=n, working reg=a, go to SHIFT.
  - SHIFT: each cycle shift the working reg by one and record the outgoing bit in carry; counter decrements. At counter==1, write result and go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE. start is acceptable in this same cycle (back-to-back).
- Latency (start edge to done high): non-shift 1 cycle; shift by n gives n+1 cycles (n=0 gives 1, n=31 gives 32).
- busy=1 in SHIFT only; start while busy is ignored, with no effect on state or outputs.
- zero/sign are computed from the final result and update only when done is asserted.
- Amount 0 shift: result=a, carry=0.

Optional Feature:
- Macro ALU_SEQ_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally with a barrel shifter and complete in 1 cycle like other ops. The SHIFT state is not synthesized and busy stays 0. carry = last bit shifted out (0 for amount 0).
- Undefined: iterative shifting as specified above.

Test Plan:
- Reset, then start with code 0000, a=0xFFFFFFFF, b=0x00000001 -> done 1 cycle later: result=0, carry=1, zero=1, sign=0.
- Code 0001, b=0x00000005 -> result=0xFFFFFFFB, carry=0, sign=1. Code 0001, b=0 -> result=0, carry=1, zero=1.
- Code 1110, a=0x80000010, b=4 -> busy for 4 cycles, done at cycle 5: result=0xF8000001, carry=0. Same with code 0101 -> result=0x08000001.
- Code 0100, a=0x00000001, b=31 -> done at cycle 32, result=0x80000000. Second start issued while busy -> ignored, and result is unchanged.
- Assert rst in 3rd cycle of a 10-bit shift -> no done pulse, all outputs 0. Next start with code 0011, a=0xF0F0F0F0, b=0xFFFF0000 -> result=0x0F0FF0F0.
- Back-to-back: start in the done cycle of a prior add, using code 1111 -> next done 1 cycle later with result=0, carry=0. With ALU_SEQ_BARREL_SHIFT_EN, a shift by 31 completes in 1 cycle with busy never 1.
